// File: rtl/l1_dcache_req_ctrl.sv
// L1 data-cache request controller. It sequences one buffered load/store op
// through translation, dcache issue, nack replay and response alignment.
module l1_dcache_req_ctrl #(
    parameter int MAX_REPLAY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [1:0]  op_bits_type_i,
    input  logic        unsigned_i,
    input  logic [2:0]  addr_lo_i,
    input  logic        dtlb_hit_i,
    input  logic        kill_i,
    input  logic        dcache_req_ready_i,
    input  logic        dcache_resp_valid_i,
    input  logic [63:0] dcache_resp_data_i,
    input  logic        dcache_nack_i,
    output logic        translation_req_o,
    output logic        trns_ena_o,
    output logic        str_rdy_o,
    output logic        mem_req_valid_o,
    output logic [63:0] ld_data_o,
    output logic        done_o,
    output logic        error_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {IDLE, TRANS, REQ, WAIT, DONE} state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_REPLAY);

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [2:0]  addr_q, addr_d;
    logic        is_ld_q, is_ld_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        drop_q, drop_d;
    logic        err_q, err_d;
    logic [63:0] ld_data_q, ld_data_d;
    logic [63:0] shifted, aligned;

    // Bytes shifted in from above bit 63 are zero, so misaligned ops read zeros.
    assign shifted = dcache_resp_data_i >> {addr_q, 3'b000};

    always_comb begin
        aligned = '0;
        case (size_q)
            2'b00:   aligned = uns_q ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'b01:   aligned = uns_q ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'b10:   aligned = uns_q ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: aligned = shifted;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        is_ld_d   = is_ld_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        drop_d    = drop_q;
        err_d     = 1'b0;
        ld_data_d = ld_data_q;

        // A stale response from a killed load is swallowed in whatever state we are in.
        if (drop_q && (dcache_resp_valid_i || dcache_nack_i))
            drop_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!kill_i) begin
                    if (is_load_i ^ is_store_i) begin
                        size_d  = op_bits_type_i;
                        uns_d   = unsigned_i;
                        addr_d  = addr_lo_i;
                        is_ld_d = is_load_i;
                        cnt_d   = '0;
                        abort_d = 1'b0;
                        state_d = TRANS;
                    end else if (is_load_i && is_store_i) begin
                        err_d = 1'b1;
                    end
                end
            end
            TRANS: begin
                if (kill_i)          state_d = IDLE;
                else if (dtlb_hit_i) state_d = REQ;
            end
            REQ: begin
                if (kill_i)                  state_d = IDLE;
                else if (dcache_req_ready_i) state_d = is_ld_q ? WAIT : DONE;
            end
            WAIT: begin
                if (kill_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end else if (!drop_q) begin
                    // Nack wins over a simultaneous response.
                    if (dcache_nack_i) begin
                        if (cnt_q < MAX_CNT) begin
                            cnt_d   = cnt_q + 3'd1;
                            state_d = REQ;
                        end else begin
                            abort_d = 1'b1;
                            state_d = DONE;
                        end
                    end else if (dcache_resp_valid_i) begin
                        ld_data_d = aligned;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            size_q    <= '0;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            is_ld_q   <= 1'b0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            is_ld_q   <= is_ld_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign translation_req_o = (state_q == TRANS);
    assign trns_ena_o        = (state_q == TRANS);
    assign str_rdy_o         = (state_q == REQ) || (state_q == WAIT) || (state_q == DONE);
    assign mem_req_valid_o   = (state_q == REQ);
    assign busy_o            = (state_q != IDLE);
    assign done_o            = (state_q == DONE) && !abort_q;
    assign error_o           = ((state_q == DONE) && abort_q) || err_q;
    assign ld_data_o         = ld_data_q;

endmodule

// File: tb/tb_l1_dcache_req_ctrl.sv
// Bench for l1_dcache_req_ctrl: directed scenarios plus randomized ops
// checked against a byte-level load-alignment model and expected op timeline.
module tb_l1_dcache_req_ctrl;

    localparam int MAX_R = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_load_i, is_store_i, unsigned_i, dtlb_hit_i, kill_i;
    logic [1:0]  op_bits_type_i;
    logic [2:0]  addr_lo_i;
    logic        dcache_req_ready_i, dcache_resp_valid_i, dcache_nack_i;
    logic [63:0] dcache_resp_data_i;
    logic        translation_req_o, trns_ena_o, str_rdy_o, mem_req_valid_o;
    logic [63:0] ld_data_o;
    logic        done_o, error_o, busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_ld = '0;

    l1_dcache_req_ctrl #(.MAX_REPLAY(MAX_R)) dut (
        .clk(clk), .rst(rst),
        .is_load_i(is_load_i), .is_store_i(is_store_i),
        .op_bits_type_i(op_bits_type_i), .unsigned_i(unsigned_i), .addr_lo_i(addr_lo_i),
        .dtlb_hit_i(dtlb_hit_i), .kill_i(kill_i),
        .dcache_req_ready_i(dcache_req_ready_i), .dcache_resp_valid_i(dcache_resp_valid_i),
        .dcache_resp_data_i(dcache_resp_data_i), .dcache_nack_i(dcache_nack_i),
        .translation_req_o(translation_req_o), .trns_ena_o(trns_ena_o),
        .str_rdy_o(str_rdy_o), .mem_req_valid_o(mem_req_valid_o),
        .ld_data_o(ld_data_o), .done_o(done_o), .error_o(error_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick bytes addr..addr+size-1 (zero past byte 7), then extend.
    function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [1:0] sz,
                                             input logic [2:0] al, input logic uns);
        logic [7:0]  b [8];
        logic [63:0] r;
        int          n;
        for (int i = 0; i < 8; i++)
            b[i] = (i + int'(al) < 8) ? d[(i + int'(al)) * 8 +: 8] : 8'h00;
        n = 1 << sz;
        r = '0;
        for (int i = 0; i < n; i++) r[i * 8 +: 8] = b[i];
        if (!uns && b[n - 1][7])
            for (int i = n; i < 8; i++) r[i * 8 +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic idle_inputs();
        is_load_i = 0; is_store_i = 0; op_bits_type_i = 0; unsigned_i = 0; addr_lo_i = 0;
        dtlb_hit_i = 0; kill_i = 0; dcache_req_ready_i = 0; dcache_resp_valid_i = 0;
        dcache_nack_i = 0; dcache_resp_data_i = '0;
    endtask

    // Drive one op through its whole life with fixed delays; checks timeline and result.
    task automatic run_op(input bit is_ld, input logic [1:0] sz, input logic [2:0] al,
                          input bit uns, input logic [63:0] data, input int hit_dly,
                          input int rdy_dly, input int resp_dly, input int nacks,
                          output int issues);
        int          nk;
        bit          exp_err;
        logic [63:0] want;
        nk = 0;
        issues = 0;
        exp_err = is_ld && (nacks > MAX_R);
        is_load_i = is_ld; is_store_i = !is_ld; op_bits_type_i = sz; addr_lo_i = al; unsigned_i = uns;
        step();
        is_load_i = 0; is_store_i = 0;
        checks++;
        if (trns_ena_o !== 1'b1 || busy_o !== 1'b1 || str_rdy_o !== 1'b0) begin
            errors++; $display("FAIL trans_entry trns_ena=%b busy=%b str_rdy=%b want 1 1 0", trns_ena_o, busy_o, str_rdy_o);
        end
        for (int i = 0; i < hit_dly; i++) begin
            step();
            checks++;
            if (translation_req_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
                errors++; $display("FAIL trans_hold treq=%b mreq=%b want 1 0", translation_req_o, mem_req_valid_o);
            end
        end
        dtlb_hit_i = 1;
        step();
        dtlb_hit_i = 0;
        forever begin
            issues++;
            checks++;
            if (mem_req_valid_o !== 1'b1 || str_rdy_o !== 1'b1 || trns_ena_o !== 1'b0) begin
                errors++; $display("FAIL req_issue mreq=%b str_rdy=%b trns=%b want 1 1 0", mem_req_valid_o, str_rdy_o, trns_ena_o);
            end
            for (int i = 0; i < rdy_dly; i++) begin
                step();
                checks++;
                if (mem_req_valid_o !== 1'b1) begin
                    errors++; $display("FAIL req_hold mreq=%b want 1", mem_req_valid_o);
                end
            end
            dcache_req_ready_i = 1;
            step();
            dcache_req_ready_i = 0;
            if (!is_ld) break;
            for (int i = 0; i < resp_dly; i++) begin
                checks++;
                if (mem_req_valid_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
                    errors++; $display("FAIL wait_hold mreq=%b busy=%b done=%b want 0 1 0", mem_req_valid_o, busy_o, done_o);
                end
                step();
            end
            if (nk < nacks) begin
                nk++;
                dcache_nack_i = 1;
                step();
                dcache_nack_i = 0;
                if (nk > MAX_R) break;
            end else begin
                dcache_resp_valid_i = 1; dcache_resp_data_i = data;
                step();
                dcache_resp_valid_i = 0;
                exp_ld = ref_load(data, sz, al, uns);
                break;
            end
        end
        checks++;
        if (done_o !== !exp_err || error_o !== exp_err) begin
            errors++; $display("FAIL op_end done=%b err=%b want %b %b", done_o, error_o, !exp_err, exp_err);
        end
        want = exp_ld;
        checks++;
        if (ld_data_o !== want) begin
            errors++; $display("FAIL ld_data got %h want %h", ld_data_o, want);
        end
        step();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0) begin
            errors++; $display("FAIL back_idle busy=%b done=%b err=%b want 0 0 0", busy_o, done_o, error_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #3;
        checks++;
        if ({translation_req_o, trns_ena_o, str_rdy_o, mem_req_valid_o, done_o, error_o, busy_o} !== 7'b0
            || ld_data_o !== 64'h0) begin
            errors++; $display("FAIL reset_outputs bits=%b ld=%h want 0", {translation_req_o, trns_ena_o,
                str_rdy_o, mem_req_valid_o, done_o, error_o, busy_o}, ld_data_o);
        end
        step();
        rst = 1;
        exp_ld = '0;
        step();
    endtask

    task automatic test_store_min();
        int iss;
        is_store_i = 1; op_bits_type_i = 2'b11; addr_lo_i = 0;
        step();
        is_store_i = 0;
        checks++;
        if (trns_ena_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
            errors++; $display("FAIL store_c1 trns=%b mreq=%b want 1 0", trns_ena_o, mem_req_valid_o);
        end
        dtlb_hit_i = 1;
        step();
        dtlb_hit_i = 0;
        checks++;
        if (mem_req_valid_o !== 1'b1 || done_o !== 1'b0) begin
            errors++; $display("FAIL store_c2 mreq=%b done=%b want 1 0", mem_req_valid_o, done_o);
        end
        dcache_req_ready_i = 1;
        step();
        dcache_req_ready_i = 0;
        checks++;
        if (done_o !== 1'b1 || mem_req_valid_o !== 1'b0 || error_o !== 1'b0) begin
            errors++; $display("FAIL store_c3 done=%b mreq=%b err=%b want 1 0 0", done_o, mem_req_valid_o, error_o);
        end
        step();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL store_c4 done=%b busy=%b want 0 0", done_o, busy_o);
        end
        run_op(0, 2'b10, 3'd4, 0, 64'hDEAD, 2, 1, 0, 0, iss);
    endtask

    task automatic test_load_vectors();
        int iss;
        run_op(1, 2'b00, 3'd3, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 0, iss);
        checks++;
        if (ld_data_o !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++; $display("FAIL load_b_signed got %h want ffffffffffffff80", ld_data_o);
        end
        run_op(1, 2'b00, 3'd3, 1, 64'h0000_0000_8000_0000, 1, 0, 2, 0, iss);
        checks++;
        if (ld_data_o !== 64'h80) begin
            errors++; $display("FAIL load_b_unsigned got %h want 80", ld_data_o);
        end
        run_op(1, 2'b01, 3'd6, 1, 64'h1234_0000_0000_0000, 0, 2, 1, 0, iss);
        checks++;
        if (ld_data_o !== 64'h1234) begin
            errors++; $display("FAIL load_h_a6 got %h want 1234", ld_data_o);
        end
        run_op(1, 2'b10, 3'd6, 0, 64'h8765_4321_0000_0000, 0, 0, 0, 0, iss);
        checks++;
        if (ld_data_o !== 64'h8765) begin
            errors++; $display("FAIL load_w_misaligned got %h want 8765", ld_data_o);
        end
    endtask

    task automatic test_replay();
        int iss;
        run_op(1, 2'b11, 3'd0, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 1, 3, iss);
        checks++;
        if (iss !== 3) begin
            errors++; $display("FAIL replay_abort_issues got %0d want 3", iss);
        end
        run_op(1, 2'b11, 3'd0, 0, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 2, iss);
        checks++;
        if (iss !== 3) begin
            errors++; $display("FAIL replay_ok_issues got %0d want 3", iss);
        end
    endtask

    task automatic test_random();
        int iss;
        for (int n = 0; n < 40; n++) begin
            run_op($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 3),
                   $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), iss);
        end
    endtask

    task automatic test_kill();
        int          iss;
        logic [63:0] want;
        // Kill in WAIT, stale response two cycles later, then a clean load.
        is_load_i = 1; op_bits_type_i = 2'b00; addr_lo_i = 0; unsigned_i = 1;
        step(); is_load_i = 0;
        dtlb_hit_i = 1; step(); dtlb_hit_i = 0;
        dcache_req_ready_i = 1; step(); dcache_req_ready_i = 0;
        kill_i = 1; step(); kill_i = 0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0) begin
            errors++; $display("FAIL kill_wait busy=%b done=%b err=%b want 0 0 0", busy_o, done_o, error_o);
        end
        step();
        dcache_resp_valid_i = 1; dcache_resp_data_i = 64'hAA;
        step(); dcache_resp_valid_i = 0;
        checks++;
        if (done_o !== 1'b0 || ld_data_o !== exp_ld) begin
            errors++; $display("FAIL stale_resp done=%b ld=%h want 0 %h", done_o, ld_data_o, exp_ld);
        end
        run_op(1, 2'b00, 3'd0, 1, 64'h55, 0, 0, 1, 0, iss);
        checks++;
        if (ld_data_o !== 64'h55) begin
            errors++; $display("FAIL after_kill_ld got %h want 55", ld_data_o);
        end
        // Kill in WAIT, new load starts at once; stale response lands in its WAIT.
        is_load_i = 1; step(); is_load_i = 0;
        dtlb_hit_i = 1; step(); dtlb_hit_i = 0;
        dcache_req_ready_i = 1; step(); dcache_req_ready_i = 0;
        kill_i = 1; step(); kill_i = 0;
        is_load_i = 1; op_bits_type_i = 2'b01; addr_lo_i = 3'd2; unsigned_i = 0;
        step(); is_load_i = 0;
        dtlb_hit_i = 1; step(); dtlb_hit_i = 0;
        dcache_req_ready_i = 1; step(); dcache_req_ready_i = 0;
        dcache_resp_valid_i = 1; dcache_resp_data_i = 64'h1111_2222_3333_4444;
        step(); dcache_resp_valid_i = 0;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++; $display("FAIL drop_in_wait busy=%b done=%b want 1 0", busy_o, done_o);
        end
        dcache_resp_valid_i = 1; dcache_resp_data_i = 64'h0000_0000_F00D_0000;
        step(); dcache_resp_valid_i = 0;
        want = ref_load(64'h0000_0000_F00D_0000, 2'b01, 3'd2, 0);
        exp_ld = want;
        checks++;
        if (done_o !== 1'b1 || ld_data_o !== want) begin
            errors++; $display("FAIL drop_then_real done=%b ld=%h want 1 %h", done_o, ld_data_o, want);
        end
        step();
    endtask

    task automatic test_reset_mid();
        is_store_i = 1; step(); is_store_i = 0;
        dtlb_hit_i = 1; step(); dtlb_hit_i = 0;
        checks++;
        if (mem_req_valid_o !== 1'b1) begin
            errors++; $display("FAIL pre_reset_req mreq=%b want 1", mem_req_valid_o);
        end
        rst = 0;
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b0 || str_rdy_o !== 1'b0 || busy_o !== 1'b0 || ld_data_o !== 64'h0) begin
            errors++; $display("FAIL async_reset mreq=%b str=%b busy=%b ld=%h want 0", mem_req_valid_o, str_rdy_o, busy_o, ld_data_o);
        end
        exp_ld = '0;
        step();
        rst = 1; is_store_i = 1;
        step(); is_store_i = 0;
        checks++;
        if (trns_ena_o !== 1'b1 || done_o !== 1'b0 || error_o !== 1'b0) begin
            errors++; $display("FAIL first_after_reset trns=%b done=%b err=%b want 1 0 0", trns_ena_o, done_o, error_o);
        end
        dtlb_hit_i = 1; step(); dtlb_hit_i = 0;
        dcache_req_ready_i = 1; step(); dcache_req_ready_i = 0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++; $display("FAIL store_after_reset done=%b want 1", done_o);
        end
        step();
    endtask

    task automatic test_both_flags();
        is_load_i = 1; is_store_i = 1;
        step();
        is_load_i = 0; is_store_i = 0;
        checks++;
        if (error_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL both_flags err=%b done=%b busy=%b want 1 0 0", error_o, done_o, busy_o);
        end
        step();
        checks++;
        if (error_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL both_flags_clear err=%b busy=%b want 0 0", error_o, busy_o);
        end
        kill_i = 1; is_load_i = 1;
        step();
        kill_i = 0; is_load_i = 0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL kill_idle_op busy=%b want 0", busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_store_min();
        test_load_vectors();
        test_replay();
        test_random();
        test_kill();
        test_reset_mid();
        test_both_flags();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
